hazard_ctrl: RTL and testbench

//  Pipeline hazard controller sequencing PC and the IF/ID register.

---
 rtl/hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the PC and the IF/ID register.
// Handles load-use stalls, jump and taken-branch flushes, and front-end
// freezes while a multicycle op occupies EX.
// Optional feature macro: HAZARD_STATS_EN adds saturating stall/flush counters.
module hazard_ctrl #(
  parameter int REG_W     = 5,
  parameter int MC_CYCLES = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             jump_in,
  input  logic             branch_taken,
  input  logic             mc_start,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       ctrl_state
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  // The counter only has to reach MC_CYCLES-2, so this width always suffices.
  localparam int MC_W = (MC_CYCLES > 2) ? $clog2(MC_CYCLES) : 1;
  localparam logic [MC_W-1:0] MC_INIT = MC_W'(MC_CYCLES - 2);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MC_STALL = 2'd1,
    REPLAY   = 2'd2,
    ILLEGAL  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [MC_W-1:0] mc_cnt, mc_cnt_nxt;
  logic            br_pend, br_pend_nxt;
  logic            load_use;

  // Load-use hazard: the load in EX writes a register the ID instruction reads.
  always_comb begin
    load_use = ex_memread && (ex_rt != '0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  end

  // State register, multicycle counter and the pending-branch flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= RUN;
      mc_cnt  <= '0;
      br_pend <= 1'b0;
    end else begin
      state   <= state_nxt;
      mc_cnt  <= mc_cnt_nxt;
      br_pend <= br_pend_nxt;
    end
  end

  // Next-state and output decode; reset forces the front end into a safe hold.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    state_nxt    = state;
    mc_cnt_nxt   = mc_cnt;
    br_pend_nxt  = br_pend;
    ctrl_state   = state;

    case (state)
      RUN: begin
        if (branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (jump_in) begin
          if_id_flush  = 1'b1;
        end else if (mc_start) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          mc_cnt_nxt   = MC_INIT;
          state_nxt    = MC_STALL;
        end else if (load_use) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
      end
      MC_STALL: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
        if (branch_taken) begin
          br_pend_nxt = 1'b1;
        end
        if (mc_cnt == '0) begin
          state_nxt = (br_pend || branch_taken) ? REPLAY : RUN;
        end else begin
          mc_cnt_nxt = mc_cnt - 1'b1;
        end
      end
      REPLAY: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        br_pend_nxt  = 1'b0;
        state_nxt    = RUN;
      end
      default: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        br_pend_nxt  = 1'b0;
        state_nxt    = RUN;
      end
    endcase

    if (!reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      ctrl_state   = 2'd0;
    end
  end

`ifdef HAZARD_STATS_EN
  // Saturating counts of frozen-PC cycles and IF/ID flush cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (if_id_flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed-vector bench for hazard_ctrl (MC_CYCLES=4).
// Inputs change on the falling edge; combinational outputs are checked 1ns later.
module tb_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [REG_W-1:0] id_rs, id_rt, ex_rt;
  logic             id_uses_rt, ex_memread, jump_in, branch_taken, mc_start;
  logic             pc_write, if_id_write, if_id_flush, id_ex_bubble;
  logic [1:0]       ctrl_state;
`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  int               exp_stall = 0;
  int               exp_flush = 0;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Expected {pc_write, if_id_write, if_id_flush, id_ex_bubble, ctrl_state}
  localparam logic [5:0] E_RST    = 6'b0011_00;
  localparam logic [5:0] E_NORMAL = 6'b1100_00;
  localparam logic [5:0] E_STALL  = 6'b0001_00;
  localparam logic [5:0] E_BRANCH = 6'b1111_00;
  localparam logic [5:0] E_JUMP   = 6'b1110_00;
  localparam logic [5:0] E_MC     = 6'b0001_01;
  localparam logic [5:0] E_REPLAY = 6'b1111_10;

  hazard_ctrl #(.REG_W(REG_W), .MC_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_memread   (ex_memread),
    .ex_rt        (ex_rt),
    .jump_in      (jump_in),
    .branch_taken (branch_taken),
    .mc_start     (mc_start),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .ctrl_state   (ctrl_state)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs on the falling edge.
  task automatic applyStimulus(input logic rst_n, input logic br, input logic jmp,
                               input logic mc, input logic mrd,
                               input logic [REG_W-1:0] ert, input logic [REG_W-1:0] rs,
                               input logic [REG_W-1:0] rt, input logic urt);
    @(negedge clk);
    reset        = rst_n;
    branch_taken = br;
    jump_in      = jmp;
    mc_start     = mc;
    ex_memread   = mrd;
    ex_rt        = ert;
    id_rs        = rs;
    id_rt        = rt;
    id_uses_rt   = urt;
    #1;
  endtask

  // Compare the decoded outputs, and the stats counters when present.
  task automatic checkOutput(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, ctrl_state};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
`ifdef HAZARD_STATS_EN
    vectors++;
    assert ({stall_cnt, flush_cnt} === {CNT_W'(exp_stall), CNT_W'(exp_flush)}) else begin
      miscompares++;
      $error("[TB] FAIL %s_cnt: observed stall=%0d flush=%0d expected stall=%0d flush=%0d",
             tag, stall_cnt, flush_cnt, exp_stall, exp_flush);
    end
    if (!reset) begin
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      if (!exp[5]) exp_stall++;
      if (exp[3])  exp_flush++;
    end
`endif
  endtask

  initial begin
    reset = 1'b0; branch_taken = 1'b0; jump_in = 1'b0; mc_start = 1'b0;
    ex_memread = 1'b0; ex_rt = '0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;

    // Reset hold and release
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("reset_c1", E_RST);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("reset_c2", E_RST);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("release", E_NORMAL);

    // Load-use on rs: exactly one stall cycle
    applyStimulus(1, 0, 0, 0, 1, 8, 8, 0, 0); checkOutput("lu_rs", E_STALL);
    applyStimulus(1, 0, 0, 0, 0, 0, 8, 0, 0); checkOutput("lu_rs_clear", E_NORMAL);
    // Load-use on rt only when rt is read
    applyStimulus(1, 0, 0, 0, 1, 9, 3, 9, 1); checkOutput("lu_rt", E_STALL);
    applyStimulus(1, 0, 0, 0, 1, 9, 3, 9, 0); checkOutput("lu_rt_unused", E_NORMAL);
    // Register zero never stalls
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 1); checkOutput("lu_r0", E_NORMAL);

    // Multicycle op: 4 frozen cycles, then resume
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 0); checkOutput("mc_c1", E_STALL);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("mc_c2", E_MC);
    applyStimulus(1, 0, 1, 0, 1, 4, 4, 0, 0); checkOutput("mc_c3_ignore", E_MC);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("mc_c4", E_MC);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("mc_c5", E_NORMAL);

    // Branch during the 2nd MC_STALL cycle leads to a REPLAY cycle
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 0); checkOutput("mcb_c1", E_STALL);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("mcb_c2", E_MC);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0); checkOutput("mcb_c3_br", E_MC);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("mcb_c4", E_MC);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("mcb_replay", E_REPLAY);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("mcb_run", E_NORMAL);

    // Jump beats load-use; branch beats jump and mc_start
    applyStimulus(1, 0, 1, 0, 1, 8, 8, 0, 0); checkOutput("jump_lu", E_JUMP);
    applyStimulus(1, 1, 1, 1, 1, 8, 8, 0, 0); checkOutput("branch_all", E_BRANCH);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("branch_stay", E_NORMAL);

    // Reset mid-stall drops the pending branch
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 0); checkOutput("rmc_c1", E_STALL);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0); checkOutput("rmc_c2_br", E_MC);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("rmc_reset", E_RST);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("rmc_run", E_NORMAL);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("rmc_no_replay", E_NORMAL);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
